universal_register_sequencer: RTL and testbench
===============================================

# universal_register_sequencer

Controller that sequences the universal shift register (hold / shift-left / shift-right / parallel load) to perform complete serial transmit and receive transactions. It accepts one command per transaction over a valid/ready handshake, drives the register's mode, parallel-load and serial-fill inputs, and observes its Q and Sout. Transmit streams a parallel word out serially; receive assembles a serial stream into a parallel word and holds it until consumed. It sits between a word-level client and the shift register instance, with the register as a separate block wired beside it.

## Interface

- N, default 8: register width in bits; legal N >= 2.

- clk  in  1  rising-edge clock, shared with the register
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, accepts command
- cmd_op  in  2  00 TX MSB-first, 01 TX LSB-first, 10 RX MSB-first, 11 RX LSB-first
- cmd_data  in  N  word to transmit; ignored for RX
- reg_mode  out  2  to register mode: 00 hold, 01 shift left, 10 shift right, 11 load
- reg_d  out  N  to register D
- reg_sin_left  out  1  to register Sin_left
- reg_sin_right  out  1  to register Sin_right
- reg_q  in  N  from register Q
- reg_sout  in  1  from register Sout
- ser_out  out  1  serial transmit bit
- ser_out_valid  out  1  ser_out carries a bit this cycle
- ser_in  in  1  serial receive bit, sampled every RX shift cycle
- rx_valid  out  1  received word available
- rx_ready  in  1  client consumes rx_data
- rx_data  out  N  received word (reg_q)
- parity_err  out  1  receive parity mismatch, qualified by rx_valid
- busy  out  1  high in every state except IDLE

## Operation

- States: IDLE, LOAD, SHIFT, PARITY (macro only), RX_DONE.
- IDLE: cmd_ready=1, reg_mode=00. On cmd_valid: latch cmd_op and cmd_data, clear bit counter, go LOAD.
- LOAD: reg_mode=11; reg_d = latched cmd_data for TX, all zeros for RX. Next SHIFT.
- SHIFT: reg_mode=01 for op 00/10, 10 for op 01/11. Lasts exactly N cycles (counter 0..N-1, width $clog2(N)+1).
  - TX: ser_out=reg_sout, ser_out_valid=1; reg_sin_left=reg_sin_right=0.
  - RX: reg_sin_left=reg_sin_right=ser_in; ser_out_valid=0.
  - After cycle N-1: TX -> IDLE (or PARITY); RX -> RX_DONE (or PARITY).
- RX_DONE: reg_mode=00, rx_valid=1, rx_data=reg_q stable; on rx_ready go IDLE.
- ser_out=0 whenever ser_out_valid=0; reg_d=0 outside LOAD; reg_sin_* = 0 outside RX SHIFT.
- cmd_valid while busy: ignored, no latch, no effect.
- MSB-first RX: first received bit ends in reg_q[N-1]; LSB-first RX: first bit ends in reg_q[0].

## Timing

- Reset (asynchronous, reset_n low): state IDLE, counter 0; cmd_ready=1, busy=0, reg_mode=00, reg_d=0, reg_sin_*=0, ser_out=0, ser_out_valid=0, rx_valid=0, parity_err=0. Mid-transaction reset abandons it; the register contents are not cleared by this block.
- Handshake accepted cycle 0; LOAD cycle 1; data bit k on ser_out / sampled from ser_in in cycle 2+k, k=0..N-1.
- TX without parity: cmd_ready high again cycle N+2. RX: rx_valid first high cycle N+2.
- rx_valid held until rx_ready; rx_ready asserted in the first rx_valid cycle gives IDLE next cycle. rx_ready outside RX_DONE ignored.
- Back-to-back: command presented in the first IDLE cycle is accepted immediately (no bubble beyond IDLE).

## Configuration

- SEQ_PARITY_EN defined: PARITY state after SHIFT, one cycle, reg_mode=00. TX: ser_out = even parity (XOR) of latched word, ser_out_valid=1; TX completes one cycle later. RX: samples ser_in as parity bit; parity_err = (^reg_q) ^ bit, registered, held with rx_valid; rx_valid first high cycle N+3.
- Undefined: no PARITY state, parity_err tied 0, timing as in ## Timing.

## Test plan

- Reset: hold reset_n low mid-SHIFT of a TX -> all outputs at reset values immediately; after release cmd_ready=1 next cycle.
- TX MSB-first, N=8, cmd_data=8'hA5 -> ser_out 1,0,1,0,0,1,0,1 in cycles 2..9 with ser_out_valid=1; cmd_ready=1 at cycle 10.
- TX LSB-first, 8'h3C -> ser_out 0,0,1,1,1,1,0,0; busy high cycles 1..9.
- RX MSB-first, ser_in 1,1,0,0,1,0,1,0 -> rx_valid cycle 10, rx_data=8'hCA; rx_ready held low 5 cycles -> rx_data stable, cmd_valid ignored.
- RX LSB-first, same stream -> rx_data=8'h53; rx_ready in first valid cycle -> IDLE next cycle, new TX accepted.
- SEQ_PARITY_EN: TX 8'h07 -> parity bit 1 at cycle 10; RX 8'h07 with parity bit 0 -> parity_err=1 at rx_valid (cycle 11).

Source files
------------

// File: rtl/universal_register_sequencer.sv
// Sequences a universal shift register through serial TX/RX word transactions.
// Optional even-parity bit after the data bits when SEQ_PARITY_EN is defined.
module universal_register_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_data,
  output logic [1:0]   reg_mode,
  output logic [N-1:0] reg_d,
  output logic         reg_sin_left,
  output logic         reg_sin_right,
  input  logic [N-1:0] reg_q,
  input  logic         reg_sout,
  output logic         ser_out,
  output logic         ser_out_valid,
  input  logic         ser_in,
  output logic         rx_valid,
  input  logic         rx_ready,
  output logic [N-1:0] rx_data,
  output logic         parity_err,
  output logic         busy
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PARITY, RX_DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic [N-1:0]    data_q;
  logic            is_rx, last_bit, accept;

  assign is_rx    = op_q[1];
  assign last_bit = (cnt == CW'(N - 1));
  assign accept   = (state == IDLE) && cmd_valid;
  assign busy     = (state != IDLE);
  assign rx_data  = reg_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      data_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SEQ_PARITY_EN
  logic perr_q;
  // Full word is in reg_q during PARITY; the incoming bit completes the even-parity check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         perr_q <= 1'b0;
    else if (accept)                      perr_q <= 1'b0;
    else if (state == PARITY && is_rx)    perr_q <= (^reg_q) ^ ser_in;
  end
  assign parity_err = perr_q & rx_valid;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d       = state;
    cmd_ready     = 1'b0;
    reg_mode      = 2'b00;
    reg_d         = '0;
    reg_sin_left  = 1'b0;
    reg_sin_right = 1'b0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    rx_valid      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = LOAD;
      end
      LOAD: begin
        reg_mode = 2'b11;
        reg_d    = is_rx ? '0 : data_q;
        state_d  = SHIFT;
      end
      SHIFT: begin
        // op bit 0 selects LSB-first, which shifts right so Sout is Q[0]
        reg_mode = op_q[0] ? 2'b10 : 2'b01;
        if (is_rx) begin
          reg_sin_left  = ser_in;
          reg_sin_right = ser_in;
        end else begin
          ser_out       = reg_sout;
          ser_out_valid = 1'b1;
        end
        if (last_bit) begin
`ifdef SEQ_PARITY_EN
          state_d = PARITY;
`else
          state_d = is_rx ? RX_DONE : IDLE;
`endif
        end
      end
`ifdef SEQ_PARITY_EN
      PARITY: begin
        if (!is_rx) begin
          ser_out       = ^data_q;
          ser_out_valid = 1'b1;
        end
        state_d = is_rx ? RX_DONE : IDLE;
      end
`endif
      RX_DONE: begin
        rx_valid = 1'b1;
        if (rx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_universal_register_sequencer.sv
// Bench for universal_register_sequencer: behavioural shift register beside the DUT,
// table vectors, randomized transactions and a mid-transaction reset.
module tb_universal_register_sequencer;
  localparam int N = 8;
`ifdef SEQ_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_data;
  logic [1:0]   reg_mode;
  logic [N-1:0] reg_d;
  logic         reg_sin_left, reg_sin_right;
  logic [N-1:0] reg_q;
  logic         reg_sout;
  logic         ser_out, ser_out_valid, ser_in;
  logic         rx_valid, rx_ready;
  logic [N-1:0] rx_data;
  logic         parity_err, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  universal_register_sequencer #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .reg_mode(reg_mode), .reg_d(reg_d),
    .reg_sin_left(reg_sin_left), .reg_sin_right(reg_sin_right), .reg_q(reg_q),
    .reg_sout(reg_sout), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
    .ser_in(ser_in), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .parity_err(parity_err), .busy(busy)
  );

  // Universal shift register: not reset by this block's reset.
  logic [N-1:0] rq = '0;
  always @(posedge clk) begin
    case (reg_mode)
      2'b01: rq <= {rq[N-2:0], reg_sin_right};
      2'b10: rq <= {reg_sin_left, rq[N-1:1]};
      2'b11: rq <= reg_d;
      default: rq <= rq;
    endcase
  end
  assign reg_q    = rq;
  assign reg_sout = (reg_mode == 2'b10) ? rq[0] : rq[N-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: k-th serial bit of a word, and word assembled from a stream.
  function automatic logic tx_bit(input logic [1:0] op, input logic [N-1:0] w, input int k);
    return op[0] ? w[k] : w[N-1-k];
  endfunction

  function automatic logic [N-1:0] rx_word(input logic [1:0] op, input logic [N-1:0] s);
    logic [N-1:0] w;
    for (int k = 0; k < N; k++)
      if (op[0]) w[k] = s[k]; else w[N-1-k] = s[k];
    return w;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mode"}, reg_mode, 0);
    chk({tag, "_d"}, reg_d, 0);
    chk({tag, "_sin"}, {reg_sin_left, reg_sin_right}, 0);
    chk({tag, "_ser"}, {ser_out, ser_out_valid}, 0);
    chk({tag, "_rxv"}, {rx_valid, parity_err}, 0);
  endtask

  // Called in the cycle the command is to be offered (DUT idle, before negedge).
  // exp_stream is bit k at index k: expected TX bits, or the RX input bits.
  task automatic run(input logic [1:0] op, input logic [N-1:0] data,
                     input logic [N-1:0] exp_stream, input logic [N-1:0] exp_word,
                     input logic pbit, input int rxw);
    logic rx;
    rx = op[1];
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    rx_ready = 1'($urandom); ser_in = 1'($urandom);
    #1;
    chk("c0_ready", cmd_ready, 1);
    chk("c0_busy", busy, 0);
    // LOAD
    @(posedge clk); #1;
    cmd_valid = 1'($urandom); cmd_op = 2'($urandom); cmd_data = N'($urandom);
    @(negedge clk);
    chk("load_mode", reg_mode, 2'b11);
    chk("load_d", reg_d, rx ? '0 : data);
    chk("load_busy", {busy, cmd_ready}, 2'b10);
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom); cmd_data = N'($urandom); rx_ready = 1'($urandom);
      ser_in = rx ? exp_stream[k] : 1'($urandom);
      @(negedge clk);
      chk("shift_mode", reg_mode, op[0] ? 2'b10 : 2'b01);
      chk("shift_busy", {busy, cmd_ready}, 2'b10);
      chk("shift_valid", ser_out_valid, !rx);
      chk("shift_ser", ser_out, rx ? 1'b0 : exp_stream[k]);
      chk("shift_sin", {reg_sin_left, reg_sin_right}, rx ? {2{exp_stream[k]}} : 2'b00);
      chk("shift_d", reg_d, 0);
    end
    if (PAR) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom); rx_ready = 1'($urandom); ser_in = pbit;
      @(negedge clk);
      chk("par_mode", reg_mode, 0);
      chk("par_ser", {ser_out_valid, ser_out}, rx ? 2'b00 : {1'b1, ^data});
      chk("par_busy", busy, 1);
    end
    if (rx) begin
      for (int w = 0; w <= rxw; w++) begin
        @(posedge clk); #1;
        cmd_valid = 1'($urandom); cmd_data = N'($urandom); ser_in = 1'($urandom);
        rx_ready = (w == rxw);
        @(negedge clk);
        chk("rx_valid", rx_valid, 1);
        chk("rx_data", rx_data, exp_word);
        chk("rx_perr", parity_err, PAR ? ((^exp_word) ^ pbit) : 1'b0);
        chk("rx_hold", {cmd_ready, reg_mode, ser_out_valid}, 0);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; rx_ready = 1'b0;
    @(negedge clk);
    chk("end_ready", cmd_ready, 1);
    chk("end_idle", {busy, rx_valid, reg_mode}, 0);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] data;
    logic [N-1:0] stream;
    logic [N-1:0] word;
    logic         pbit;
    int           rxw;
  } vec_t;

  initial begin
    vec_t tbl[4];
    logic [1:0]   op;
    logic [N-1:0] data, strm, w;
    logic         pb;
    tbl[0] = '{2'b00, 8'hA5, 8'hA5, 8'h00, 1'b0, 0};
    tbl[1] = '{2'b01, 8'h3C, 8'h3C, 8'h00, 1'b0, 0};
    tbl[2] = '{2'b10, 8'h00, 8'b0101_0011, 8'hCA, 1'b0, 5};
    tbl[3] = '{2'b11, 8'h00, 8'b0101_0011, 8'h53, 1'b1, 0};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    ser_in = 1'b0; rx_ready = 1'b0;
    #1;
    chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", cmd_ready, 1);

    for (int i = 0; i < 4; i++)
      run(tbl[i].op, tbl[i].data, tbl[i].stream, tbl[i].word, tbl[i].pbit, tbl[i].rxw);

    for (int i = 0; i < 24; i++) begin
      op   = 2'($urandom);
      data = N'($urandom);
      strm = N'($urandom);
      pb   = 1'($urandom);
      if (op[1]) w = rx_word(op, strm);
      else begin
        w = '0;
        for (int k = 0; k < N; k++) strm[k] = tx_bit(op, data, k);
      end
      run(op, data, strm, w, pb, int'($urandom_range(0, 3)));
    end

    // Reset asserted in the middle of a TX shift.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'hA5;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    run(2'b01, 8'h96, 8'h96, 8'h00, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
